// File: rtl/raster_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : raster_scheduler_if
// Brief    : Descriptor intake, rasterizer handshake and frame-buffer write bus.
// Revision : 1.0
// ============================================================================
interface raster_scheduler_if #(
  parameter int DESC_W = 230,
  parameter int ADDR_W = 17
);
  logic              tri_valid;
  logic [DESC_W-1:0] tri_desc;
  logic              tri_ready;
  logic [DESC_W-1:0] cur_desc;
  logic              rasterizer_start;
  logic              rasterizer_done;
  logic              ras_we;
  logic [7:0]        ras_din;
  logic [ADDR_W-1:0] ras_addr;
  logic              fb_we;
  logic [7:0]        fb_din;
  logic [ADDR_W-1:0] fb_addr;

  // master: CPU / rasterizer / frame-buffer side; slave: the scheduler itself
  modport master (
    output tri_valid, tri_desc, rasterizer_done, ras_we, ras_din, ras_addr,
    input  tri_ready, cur_desc, rasterizer_start, fb_we, fb_din, fb_addr
  );

  modport slave (
    input  tri_valid, tri_desc, rasterizer_done, ras_we, ras_din, ras_addr,
    output tri_ready, cur_desc, rasterizer_start, fb_we, fb_din, fb_addr
  );
endinterface
`default_nettype wire

// File: rtl/raster_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : raster_scheduler
// Brief    : Per-frame sequencer: descriptor FIFO, frame-buffer clear, triangle
//            dispatch to the rasterizer and frame-buffer write-port mux.
// Revision : 1.0
// ============================================================================
module raster_scheduler #(
  parameter int DESC_W    = 230,
  parameter int DEPTH     = 4,
  parameter int FB_PIXELS = 76800,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  raster_scheduler_if.slave bus,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              clear_en,
  input  logic [7:0]        clear_color,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       tri_count
);

  localparam int                c_PTR_W     = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = 1;
  localparam logic [c_PTR_W:0]  c_CNT_ONE   = 1;
  localparam logic [c_PTR_W:0]  c_CNT_FULL  = DEPTH[c_PTR_W:0];
  localparam logic [ADDR_W-1:0] c_ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_CLEAR    = 3'd1;
  localparam logic [2:0] c_WAIT_TRI = 3'd2;
  localparam logic [2:0] c_START    = 3'd3;
  localparam logic [2:0] c_RASTER   = 3'd4;
  localparam logic [2:0] c_DONE     = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [DESC_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [DESC_W-1:0]  r_cur_desc;
  logic               r_start;
  logic               r_end_seen;
  logic [15:0]        r_tri_count;
  logic [ADDR_W-1:0]  r_clr_addr;
  logic [7:0]         r_clr_color;
  logic [ADDR_W-1:0]  r_hold_addr;
  logic [7:0]         r_hold_din;

  logic               w_push;
  logic               w_pop;
  logic               w_frame_go;
  logic               w_fb_we;
  logic [ADDR_W-1:0]  w_fb_addr;
  logic [7:0]         w_fb_din;

  assign w_push     = bus.tri_valid && bus.tri_ready;
  assign w_pop      = (r_state == c_WAIT_TRI) && (r_count != '0);
  assign w_frame_go = (r_state == c_IDLE) && frame_start;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:     if (frame_start) w_next_state = clear_en ? c_CLEAR : c_WAIT_TRI;
      c_CLEAR:    if (r_clr_addr == c_LAST_ADDR) w_next_state = c_WAIT_TRI;
      c_WAIT_TRI: begin
        if (r_count != '0)                 w_next_state = c_START;
        else if (r_end_seen || frame_end)  w_next_state = c_DONE;
      end
      c_START:    w_next_state = c_RASTER;
      c_RASTER:   if (bus.rasterizer_done) w_next_state = c_WAIT_TRI;
      c_DONE:     w_next_state = c_IDLE;
      default:    w_next_state = c_IDLE;
    endcase
  end

  // Output logic: the frame-buffer port holds its last address/data when idle
  always_comb begin
    w_fb_we    = 1'b0;
    w_fb_addr  = r_hold_addr;
    w_fb_din   = r_hold_din;
    busy       = (r_state != c_IDLE);
    frame_done = (r_state == c_DONE);
    case (r_state)
      c_CLEAR: begin
        w_fb_we   = 1'b1;
        w_fb_addr = r_clr_addr;
        w_fb_din  = r_clr_color;
      end
      c_RASTER: begin
        w_fb_we   = bus.ras_we;
        w_fb_addr = bus.ras_addr;
        w_fb_din  = bus.ras_din;
      end
      default: ;
    endcase
  end

  // Storage array carries no reset; validity is tracked by r_count alone
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.tri_desc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cur_desc  <= '0;
      r_start     <= 1'b0;
      r_end_seen  <= 1'b0;
      r_tri_count <= '0;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
      r_hold_addr <= '0;
      r_hold_din  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
        r_cur_desc <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: ;
      endcase

      // Start is registered so it lands on the first RASTER cycle
      r_start <= (r_state == c_START);

      if (w_frame_go) begin
        r_end_seen  <= 1'b0;
        r_tri_count <= '0;
        r_clr_addr  <= '0;
        r_clr_color <= clear_color;
      end else if (frame_end && (r_state != c_IDLE)) begin
        r_end_seen <= 1'b1;
      end

      if (r_state == c_CLEAR) r_clr_addr <= r_clr_addr + c_ADDR_ONE;

      if ((r_state == c_RASTER) && bus.rasterizer_done && (r_tri_count != 16'hFFFF))
        r_tri_count <= r_tri_count + 16'd1;

      if ((r_state == c_CLEAR) || (r_state == c_RASTER)) begin
        r_hold_addr <= w_fb_addr;
        r_hold_din  <= w_fb_din;
      end
    end
  end

  assign bus.tri_ready        = (r_count != c_CNT_FULL);
  assign bus.cur_desc         = r_cur_desc;
  assign bus.rasterizer_start = r_start;
  assign bus.fb_we            = w_fb_we;
  assign bus.fb_addr          = w_fb_addr;
  assign bus.fb_din           = w_fb_din;
  assign tri_count            = r_tri_count;

endmodule
`default_nettype wire

// File: tb/tb_raster_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_scheduler
// Brief    : Self-checking bench for raster_scheduler with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_raster_scheduler;
  localparam int DESC_W    = 230;
  localparam int DEPTH     = 4;
  localparam int FB_PIXELS = 76800;
  localparam int ADDR_W    = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end   = 1'b0;
  logic        clear_en    = 1'b0;
  logic [7:0]  clear_color = 8'h00;
  logic        busy;
  logic        frame_done;
  logic [15:0] tri_count;

  raster_scheduler_if #(.DESC_W(DESC_W), .ADDR_W(ADDR_W)) bus ();

  raster_scheduler #(
    .DESC_W(DESC_W), .DEPTH(DEPTH), .FB_PIXELS(FB_PIXELS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .frame_start(frame_start), .frame_end(frame_end),
    .clear_en(clear_en), .clear_color(clear_color),
    .busy(busy), .frame_done(frame_done), .tri_count(tri_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [DESC_W-1:0] act, input logic [DESC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DESC_W-1:0] rand_desc();
    logic [DESC_W-1:0] d = '0;
    for (int i = 0; i < 8; i++) d = {d[DESC_W-33:0], 32'($urandom)};
    return d;
  endfunction

  // ---------------- frame-level reference model ----------------
  typedef enum int {M_IDLE, M_CLEAR, M_WAIT, M_ARM, M_RUN, M_FIN} ph_t;
  ph_t               ph;
  logic [DESC_W-1:0] mq[$];
  logic [DESC_W-1:0] m_cur;
  int                m_cnt;
  bit                m_end;
  int                m_clr;
  logic [7:0]        m_color;
  logic [ADDR_W-1:0] m_last_addr;
  logic [7:0]        m_last_din;
  bit                m_pulse;

  task automatic m_reset();
    ph = M_IDLE; mq.delete(); m_cur = '0; m_cnt = 0; m_end = 0; m_clr = 0;
    m_color = '0; m_last_addr = '0; m_last_din = '0; m_pulse = 0;
  endtask

  // Observation logs for the directed literal checks
  int   st_we, st_first_addr, st_last_addr, st_bad_din, st_fd, fd_cyc, fs_cyc;
  logic [7:0] st_din_ref;
  int   start_cyc[$];
  logic [DESC_W-1:0] start_desc[$];
  int   done_cyc[$];

  task automatic clr_stats();
    st_we = 0; st_first_addr = -1; st_last_addr = -1; st_bad_din = 0; st_fd = 0; fd_cyc = -1;
    start_cyc.delete(); start_desc.delete(); done_cyc.delete();
  endtask

  always @(negedge clk) begin : b_chk
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_din;
    bit                pushed, end_now;
    logic [DESC_W-1:0] pd;
    if (!rst) m_reset();
    e_we = 1'b0; e_addr = m_last_addr; e_din = m_last_din;
    if (ph == M_CLEAR) begin
      e_we = 1'b1; e_addr = ADDR_W'(m_clr); e_din = m_color;
    end else if (ph == M_RUN) begin
      e_we = bus.ras_we; e_addr = bus.ras_addr; e_din = bus.ras_din;
    end
    chk("tri_ready",  bus.tri_ready, (mq.size() != DEPTH));
    chk("busy",       busy, (ph != M_IDLE));
    chk("frame_done", frame_done, (ph == M_FIN));
    chk("ras_start",  bus.rasterizer_start, m_pulse);
    chk("fb_we",      bus.fb_we, e_we);
    chk("fb_addr",    bus.fb_addr, e_addr);
    chk("fb_din",     bus.fb_din, e_din);
    chk("cur_desc",   bus.cur_desc, m_cur);
    chk("tri_count",  tri_count, 16'(m_cnt));

    if (bus.fb_we) begin
      if (st_first_addr < 0) st_first_addr = int'(bus.fb_addr);
      st_last_addr = int'(bus.fb_addr);
      st_we++;
      if (bus.fb_din != st_din_ref) st_bad_din++;
    end
    if (bus.rasterizer_start) begin
      start_cyc.push_back(cyc);
      start_desc.push_back(bus.cur_desc);
    end
    if (frame_done) begin st_fd++; fd_cyc = cyc; end

    if (rst) begin
      if (ph == M_CLEAR || ph == M_RUN) begin m_last_addr = e_addr; m_last_din = e_din; end
      m_pulse = (ph == M_ARM);
      pushed  = bus.tri_valid && (mq.size() != DEPTH);
      pd      = bus.tri_desc;
      end_now = m_end || frame_end;
      if (frame_end && ph != M_IDLE) m_end = 1;
      case (ph)
        M_IDLE: if (frame_start) begin
          m_cnt = 0; m_end = 0; m_color = clear_color; m_clr = 0;
          ph = clear_en ? M_CLEAR : M_WAIT;
        end
        M_CLEAR: begin
          if (m_clr == FB_PIXELS - 1) ph = M_WAIT;
          m_clr++;
        end
        M_WAIT: begin
          if (mq.size() != 0) begin m_cur = mq.pop_front(); ph = M_ARM; end
          else if (end_now) ph = M_FIN;
        end
        M_ARM: ph = M_RUN;
        M_RUN: if (bus.rasterizer_done) begin
          if (m_cnt < 65535) m_cnt++;
          ph = M_WAIT;
        end
        M_FIN: ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
      if (pushed) mq.push_back(pd);
    end
    cyc++;
  end

  // ---------------- rasterizer stand-in ----------------
  int ras_lat = 20;
  bit ras_stall = 0;
  bit spur_en = 0;

  initial begin : b_ras
    int left;
    bit running;
    running = 0; left = 0;
    bus.rasterizer_done = 1'b0; bus.ras_we = 1'b0; bus.ras_din = '0; bus.ras_addr = '0;
    forever begin
      @(posedge clk); #1;
      bus.ras_we   = 1'($urandom);
      bus.ras_din  = 8'($urandom);
      bus.ras_addr = ADDR_W'($urandom);
      bus.rasterizer_done = 1'b0;
      if (!rst) running = 0;
      else if (bus.rasterizer_start) begin running = 1; left = ras_lat; end
      else if (running) begin
        if (!ras_stall) begin
          left--;
          if (left <= 0) begin bus.rasterizer_done = 1'b1; running = 0; done_cyc.push_back(cyc); end
        end
      end else if (spur_en && $urandom_range(0, 15) == 0) bus.rasterizer_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit ce, input logic [7:0] col);
    clear_en = ce; clear_color = col; frame_start = 1'b1; fs_cyc = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
  endtask

  task automatic push(input logic [DESC_W-1:0] d, output int acc);
    int n = 0;
    acc = -1;
    bus.tri_valid = 1'b1; bus.tri_desc = d;
    while (acc < 0 && n < 500) begin
      if (bus.tri_ready) acc = cyc;
      tick(); n++;
    end
    if (acc < 0) chk("push_timeout", bus.tri_ready, 1);
    bus.tri_valid = 1'b0;
  endtask

  task automatic wait_fd(input int lim);
    int n = 0;
    while (!frame_done && n < lim) begin tick(); n++; end
    chk("frame_done_seen", frame_done, 1);
    tick();
  endtask

  initial begin : b_main
    logic [DESC_W-1:0] d[5];
    int acc, acc5, n;
    bus.tri_valid = 1'b0; bus.tri_desc = '0;
    st_din_ref = 8'h00;
    clr_stats();
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("rst_tri_ready", bus.tri_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fb_we", bus.fb_we, 0);
    chk("rst_cur_desc", bus.cur_desc, 0);
    rst = 1'b1;
    clr_stats();
    repeat (10) tick();
    chk("idle_we_cycles", st_we, 0);

    // Clear-only frame
    clr_stats(); st_din_ref = 8'h1C;
    pulse_start(1, 8'h1C);
    repeat (4) tick();
    pulse_end();
    wait_fd(80000);
    repeat (4) tick();
    chk("clr_we_cycles", st_we, 76800);
    chk("clr_first_addr", st_first_addr, 0);
    chk("clr_last_addr", st_last_addr, 76799);
    chk("clr_bad_din", st_bad_din, 0);
    chk("clr_fd_pulses", st_fd, 1);
    chk("clr_tri_count", tri_count, 0);

    // Three preloaded triangles
    ras_lat = 20;
    for (int i = 0; i < 3; i++) begin d[i] = rand_desc(); push(d[i], acc); end
    clr_stats();
    pulse_start(0, 8'h00);
    repeat (3) tick();
    pulse_end();
    wait_fd(500);
    chk("t3_starts", start_cyc.size(), 3);
    if (start_cyc.size() == 3 && done_cyc.size() == 3) begin
      chk("t3_first_lat", start_cyc[0] - fs_cyc, 3);
      for (int i = 0; i < 3; i++) begin
        chk("t3_desc", start_desc[i], d[i]);
        chk("t3_run_len", done_cyc[i] - start_cyc[i], 20);
        if (i > 0) chk("t3_done_to_start", start_cyc[i] - done_cyc[i-1], 3);
      end
      chk("t3_fd_lat", fd_cyc - done_cyc[2], 2);
    end
    chk("t3_tri_count", tri_count, 3);

    // Backpressure with stalled rasterizer
    ras_stall = 1; ras_lat = 5;
    for (int i = 0; i < 4; i++) begin d[i] = rand_desc(); push(d[i], acc); end
    d[4] = rand_desc();
    chk("bp_ready_full", bus.tri_ready, 0);
    clr_stats();
    fork
      push(d[4], acc5);
      begin repeat (3) tick(); pulse_start(0, 8'h00); end
    join
    chk("bp_fifth_accept", acc5 - fs_cyc, 2);
    ras_stall = 0;
    pulse_end();
    wait_fd(1000);
    chk("bp_starts", start_cyc.size(), 5);
    if (start_cyc.size() == 5)
      for (int i = 0; i < 5; i++) chk("bp_desc", start_desc[i], d[i]);
    chk("bp_tri_count", tri_count, 5);

    // frame_end while rastering with one queued
    ras_lat = 20;
    for (int i = 0; i < 2; i++) begin d[i] = rand_desc(); push(d[i], acc); end
    clr_stats();
    pulse_start(0, 8'h00);
    n = 0;
    while (start_cyc.size() < 1 && n < 100) begin tick(); n++; end
    tick(); tick();
    pulse_end();
    wait_fd(500);
    chk("fe_starts", start_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("fe_fd_after_done", fd_cyc - done_cyc[1], 2);
    chk("fe_tri_count", tri_count, 2);

    // Async reset mid-clear, then restart
    d[0] = rand_desc(); push(d[0], acc);
    pulse_start(1, 8'hA5);
    repeat (1000) tick();
    chk("ar_addr_1000", bus.fb_addr, 1000);
    chk("ar_we_before", bus.fb_we, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_we_dropped", bus.fb_we, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", bus.tri_ready, 1);
    tick(); tick();
    rst = 1'b1;
    pulse_start(1, 8'h33);
    chk("ar_restart_addr", bus.fb_addr, 0);
    chk("ar_restart_din", bus.fb_din, 8'h33);
    repeat (5) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    clr_stats();
    pulse_start(0, 8'h00);
    pulse_end();
    wait_fd(100);
    chk("ar_fifo_lost", start_cyc.size(), 0);

    // Randomised traffic
    spur_en = 1;
    for (int k = 0; k < 3000; k++) begin
      bus.tri_valid = ($urandom_range(0, 2) == 0);
      bus.tri_desc  = rand_desc();
      frame_start   = ($urandom_range(0, 24) == 0);
      frame_end     = ($urandom_range(0, 14) == 0);
      clear_en      = 1'b0;
      clear_color   = 8'($urandom);
      ras_lat       = $urandom_range(1, 8);
      ras_stall     = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.tri_valid = 1'b0; frame_start = 1'b0; ras_stall = 0; spur_en = 0;
    n = 0;
    while (busy && n < 3000) begin frame_end = 1'b1; tick(); n++; end
    frame_end = 1'b0;
    tick();
    chk("drain_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/raster_scheduler.md
Name: raster_scheduler

Overview:
- Per-frame sequencer in front of the rasterizer.
- Buffers triangle descriptors pushed by the MicroBlaze in a small FIFO and clears the frame buffer at frame start.
- Dispatches triangles to the rasterizer one at a time using its start/done handshake, and signals frame completion.
- Owns the frame-buffer write port: muxes the clear engine and the rasterizer writes onto it.

Parameters:
- DESC_W, 230: triangle descriptor width. Packing, MSB to LSB: inv_area[32], color[8], a1,b1,a2,b2,a3,b3[9 each], c1,c2,c3[18 each], bbxi[9], bbxf[9], bbyi[8], bbyf[8], z1,z2,z3[16 each].
- DEPTH, 4: descriptor FIFO entries; power of two.
- FB_PIXELS, 76800: frame-buffer pixels (320x240).
- ADDR_W, 17: frame-buffer address width.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous, active-low reset (asserted when 0).
- tri_valid in 1: descriptor offered.
- tri_desc in DESC_W: descriptor; accepted when tri_valid && tri_ready.
- tri_ready out 1: FIFO not full.
- frame_start in 1: 1-cycle pulse, begin frame.
- frame_end in 1: 1-cycle pulse, no more triangles this frame.
- clear_en in 1: clear frame buffer at frame start.
- clear_color in 8: clear value.
- cur_desc out DESC_W: descriptor to the rasterizer; held stable for the whole run.
- rasterizer_start out 1: 1-cycle start pulse.
- rasterizer_done in 1: rasterizer completion pulse.
- ras_we in 1, ras_din in 8, ras_addr in ADDR_W: rasterizer frame-buffer write request.
- fb_we out 1, fb_din out 8, fb_addr out ADDR_W: frame-buffer write port.
- busy out 1: state != IDLE.
- frame_done out 1: 1-cycle pulse when the frame is finished.
- tri_count out 16: triangles completed this frame; saturates at 65535.

Behaviour:
- Reset values:
  - tri_ready=1 (FIFO empty).
  - All other outputs 0; cur_desc=0.
  - FIFO emptied; end_seen flag=0; state=IDLE.
  - The top level resets the rasterizer from the same reset event.
- FIFO:
  - Push on tri_valid && tri_ready in any state, including IDLE, so the next frame can be preloaded.
  - A push and a pop in the same cycle leaves the count unchanged.
  - tri_ready = (count != DEPTH).
  - Pointers wrap mod DEPTH. Order is strictly FIFO.
- end_seen flag:
  - Set by frame_end in any state except IDLE.
  - Cleared on frame accept.
  - frame_end in IDLE is ignored; frame_start outside IDLE is ignored.
- IDLE:
  - On frame_start: tri_count<=0, end_seen<=0.
  - Go to CLEAR if clear_en, else WAIT_TRI; clr_addr<=0.
- CLEAR:
  - Each cycle: fb_we=1, fb_addr=clr_addr, fb_din=clear_color (latched at frame_start); clr_addr increments.
  - After clr_addr==FB_PIXELS-1 → WAIT_TRI.
  - Exactly FB_PIXELS write cycles; ras_* ignored.
- WAIT_TRI:
  - If FIFO non-empty: cur_desc<=head, pop, → START.
  - Else if end_seen (including set this cycle) → DONE.
  - Else stay.
- START: rasterizer_start=1 for exactly one cycle → RASTER.
- RASTER:
  - fb_we=ras_we, fb_din=ras_din, fb_addr=ras_addr, combinational pass-through.
  - On rasterizer_done: tri_count+1 (saturating) → WAIT_TRI.
- DONE: frame_done=1 for one cycle → IDLE.
- Frame-buffer gating:
  - Outside CLEAR and RASTER: fb_we=0; fb_addr/fb_din hold their last values.
  - ras_we is forced low outside RASTER.
- Latencies:
  - Non-empty FIFO in WAIT_TRI to rasterizer_start: 2 cycles.
  - rasterizer_done to next rasterizer_start: 3 cycles when the FIFO is non-empty.
- cur_desc changes only on a WAIT_TRI pop. It is never modified during START or RASTER.
- rasterizer_done outside RASTER is ignored.
- Reset mid-operation (async): fb_we and rasterizer_start drop immediately without a clock edge; FIFO contents are lost; no frame_done is issued.
- The z-buffer clear is out of scope for this block.

Test Plan:
- Reset: hold rst=0 → all outputs 0, tri_ready=1, busy=0. Release rst and idle 10 cycles → no activity.
- Clear-only frame: clear_en=1, clear_color=0x1C, frame_start, then frame_end 5 cycles later, no triangles → 76800 consecutive fb_we cycles, addresses 0..76799, data 0x1C; then exactly one frame_done; tri_count=0.
- Three triangles with descriptors D0,D1,D2 preloaded in IDLE, clear_en=0, and a rasterizer model asserting done 20 cycles after start → three start pulses with cur_desc=D0,D1,D2 in order, 2 cycles from WAIT_TRI to each start, tri_count=3. With frame_end issued, frame_done follows the third done.
- Backpressure (DEPTH=4): rasterizer stalled, 5 pushes → tri_ready=0 after the 4th; the 5th is held until the first pop, then accepted; no descriptor lost or duplicated.
- frame_end during RASTER with 1 descriptor still queued → the queued triangle is dispatched; frame_done only after its done; tri_count=2.
- Async reset at clr_addr=1000 during CLEAR → fb_we=0 before the next edge, state IDLE, FIFO empty; a subsequent frame starts again from clr_addr 0.
